// File: rtl/key_filter_pkg.sv
// Shared types and timing constants for the multi-channel key debouncer.
package key_filter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_DEB = 2'd3
    } key_fsm_t;

    // Board values assume a 50 MHz clock; the _SIM values keep simulations short.
    localparam int unsigned CNT_20MS     = 999_999;
    localparam int unsigned CNT_1S       = 49_999_999;
    localparam int unsigned CNT_20MS_SIM = 19;
    localparam int unsigned CNT_1S_SIM   = 99;

endpackage

// File: rtl/key_filter_chan.sv
// One debounce channel: 2-flop synchroniser, debounce FSM and counter.
// Long-press hold counter is built only when KEY_FILTER_LONG_EN is defined.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int unsigned CNT_MAX  = CNT_20MS,
    parameter int unsigned LONG_MAX = CNT_1S
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       sync_q;
    logic             key_sync;
    key_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_out_q, state_out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign key_sync = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        state_out_d = state_out_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_sync) begin
                    state_d = PRESS_DEB;
                    cnt_d   = '0;
                end
            end
            PRESS_DEB: begin
                if (key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_d     = 1'b1;
                    state_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_sync) begin
                    state_d = RELEASE_DEB;
                    cnt_d   = '0;
                end
            end
            RELEASE_DEB: begin
                if (!key_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    release_d   = 1'b1;
                    state_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            state_out_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            state_out_q <= state_out_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign key_state   = state_out_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_FILTER_LONG_EN
    localparam int LONG_W = $clog2(LONG_MAX + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);
    localparam logic [LONG_W-1:0] LONG_DONE = LONG_W'(LONG_MAX);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_q, long_d;

    // Parking the counter at LONG_MAX after firing blocks repeats until a new press.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (state_q == PRESS_DEB && state_d == PRESSED) begin
            long_cnt_d = '0;
        end else if (state_q == PRESSED || state_q == RELEASE_DEB) begin
            if (state_d == IDLE) begin
                long_cnt_d = '0;
            end else if (long_cnt_q == LONG_LAST) begin
                long_cnt_d = LONG_DONE;
                long_d     = 1'b1;
            end else if (long_cnt_q != LONG_DONE) begin
                long_cnt_d = long_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter_multi.sv
// KEY_NUM independent active-low key debouncers with press/release/long pulses.
// Long-press detection is enabled by defining KEY_FILTER_LONG_EN.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int unsigned KEY_NUM  = 4,
    parameter int unsigned CNT_MAX  = CNT_20MS,
    parameter int unsigned LONG_MAX = CNT_1S
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_chan
            key_filter_chan #(
                .CNT_MAX  (CNT_MAX),
                .LONG_MAX (LONG_MAX)
            ) u_chan (
                .sys_clk     (sys_clk),
                .sys_rst_n   (sys_rst_n),
                .key_in      (key_in[gi]),
                .key_state   (key_state[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_long    (key_long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_filter_multi.sv
// Self-checking bench for key_filter_multi: vector table plus hand sequences,
// with a scoreboard of expected pulse cycles.
module tb_key_filter_multi;
    import key_filter_pkg::*;

    localparam int KN   = 4;
    localparam int LAT  = 21;  // pulse seen at first-sample edge + 21 (22nd edge)
    localparam int LONG = 99;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [KN-1:0] key_in = '0;
    logic [KN-1:0] key_state, key_press, key_release, key_long;

    key_filter_multi #(
        .KEY_NUM  (KN),
        .CNT_MAX  (CNT_20MS_SIM),
        .LONG_MAX (CNT_1S_SIM)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 long
    } exp_t;

    typedef struct {
        int ch;
        int low_len;
        bit exp_press;
    } vec_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string kname[3];

    task automatic push_ev(input int c, input int ch, input int kind);
        exp_t e;
        e.cyc = c; e.ch = ch; e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [KN-1:0] act, input logic [KN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, act, req, cyc);
        end else begin
            $display("ok   %s = %b at cycle %0d", name, act, cyc);
        end
    endtask

    // Advance one cycle and reconcile every observed pulse against the scoreboard.
    task automatic tick();
        bit p;
        int idx;
        @(negedge sys_clk);
        for (int ch = 0; ch < KN; ch++) begin
            for (int k = 0; k < 3; k++) begin
                p = (k == 0) ? key_press[ch] : (k == 1) ? key_release[ch] : key_long[ch];
                if (p) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].ch == ch && exp_q[i].kind == k) idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected %s[%0d] at cycle %0d", kname[k], ch, cyc);
                    end else begin
                        if (exp_q[idx].cyc != cyc) begin
                            errors++;
                            $display("FAIL %s[%0d] timing: got cycle %0d want cycle %0d",
                                     kname[k], ch, cyc, exp_q[idx].cyc);
                        end else begin
                            $display("ok   %s[%0d] at cycle %0d", kname[k], ch, cyc);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing %s[%0d]: got no pulse want cycle %0d",
                         kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    vec_t vecs[6];

    initial begin
        int e;
        int r;
        kname[0] = "key_press"; kname[1] = "key_release"; kname[2] = "key_long";
        vecs[0] = '{0, 60, 1'b1};   // clean press
        vecs[1] = '{2, 19, 1'b0};   // one cycle short of the minimum
        vecs[2] = '{2, 20, 1'b1};   // exactly the minimum
        vecs[3] = '{3, 21, 1'b1};
        vecs[4] = '{1, 5,  1'b0};
        vecs[5] = '{1, 1,  1'b0};

        // Reset with all keys low
        ticks(3);
        check_val("reset key_state",   key_state,   '0);
        check_val("reset key_press",   key_press,   '0);
        check_val("reset key_release", key_release, '0);
        check_val("reset key_long",    key_long,    '0);
        key_in = '1;
        sys_rst_n = 1'b1;
        ticks(200);
        check_val("idle key_state", key_state, '0);

        // Table-driven single-key vectors
        for (int v = 0; v < 6; v++) begin
            key_in[vecs[v].ch] = 1'b0;
            e = cyc + 1;
            if (vecs[v].exp_press) push_ev(e + LAT, vecs[v].ch, 0);
            ticks(vecs[v].low_len);
            key_in[vecs[v].ch] = 1'b1;
            r = cyc + 1;
            if (vecs[v].exp_press) push_ev(r + LAT, vecs[v].ch, 1);
            ticks(20);
            check_val($sformatf("vec%0d held key_state", v), key_state,
                      vecs[v].exp_press ? (KN'(1) << vecs[v].ch) : '0);
            ticks(25);
            check_val($sformatf("vec%0d after key_state", v), key_state, '0);
        end

        // Bounce on key 1: toggle every 3 cycles for 30 cycles, then stay low
        for (int s = 0; s < 10; s++) begin
            key_in[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
            ticks(3);
        end
        key_in[1] = 1'b0;
        e = cyc + 1;
        push_ev(e + LAT, 1, 0);
        ticks(40);
        check_val("bounce key_state", key_state, 4'b0010);
        key_in[1] = 1'b1;
        r = cyc + 1;
        push_ev(r + LAT, 1, 1);
        ticks(30);

        // Simultaneous presses on keys 0 and 3, then reset while pressed
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        e = cyc + 1;
        push_ev(e + LAT, 0, 0);
        push_ev(e + LAT, 3, 0);
        ticks(25);
        check_val("simul key_state", key_state, 4'b1001);
        tick();
        #3 sys_rst_n = 1'b0;
        #1;
        check_val("async reset key_state", key_state, '0);
        ticks(3);
        sys_rst_n = 1'b1;
        e = cyc + 1;
        push_ev(e + LAT, 0, 0);
        push_ev(e + LAT, 3, 0);
        ticks(30);
        check_val("post-reset key_state", key_state, 4'b1001);
        key_in = '1;
        r = cyc + 1;
        push_ev(r + LAT, 0, 1);
        push_ev(r + LAT, 3, 1);
        ticks(30);

        // Long hold on key 0
        key_in[0] = 1'b0;
        e = cyc + 1;
        push_ev(e + LAT, 0, 0);
`ifdef KEY_FILTER_LONG_EN
        push_ev(e + LAT + LONG, 0, 2);
`endif
        ticks(200);
        check_val("long hold key_state", key_state, 4'b0001);
        key_in[0] = 1'b1;
        r = cyc + 1;
        push_ev(r + LAT, 0, 1);
        ticks(40);
        check_val("final key_long", key_long, '0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
